mux_4to1: RTL and testbench
===========================

# mux_4to1

4:1 bit-select multiplexer with a combinational output and a registered, valid-qualified copy of the same result. The combinational path drives `Y = X[sel]` for glue logic. The registered path gives downstream synchronous logic a one-cycle, reset-clean version of the output. The block sits at the leaf level of datapath steering logic and is instantiated wherever one of four lanes must be picked by a 2-bit select.

## Interface
Clock is `clk`; reset is `rst`, asynchronous and active-high. The block has one clock domain.

Parameters:
- `W`, default 1: width of each lane in bits. The default W=1 gives the classic 4-bit X, 1-bit Y form.

Ports:
- `clk`  input  1  rising-edge clock for the registered path.
- `rst`  input  1  asynchronous, active-high reset. Clears the registered outputs only.
- `X`  input  4*W  four data lanes. Lane k occupies `X[k*W +: W]`.
- `sel`  input  2  lane select: 0 → lane 0, 1 → lane 1, 2 → lane 2, 3 → lane 3.
- `in_valid`  input  1  qualifies X/sel for capture into the registered path.
- `Y`  output  W  combinational result, lane `sel` of X.
- `y_q`  output  W  registered result.
- `out_valid`  output  1  y_q holds a captured value this cycle.

## Operation
Combinational path:
- `Y = X[sel*W +: W]` for every value of sel. No default lane or X-propagation masking is needed beyond what falls out of full decode.
- All four sel values are decoded. Y responds to any change on X or sel with no dependency on `clk`, `rst` or `in_valid`.
- If X or sel is X/Z in simulation, Y is X. No masking is applied.

Registered path:
- On a rising `clk` edge with `in_valid=1`: `y_q <= Y` and `out_valid <= 1`.
- On a rising `clk` edge with `in_valid=0`: y_q holds its value and `out_valid <= 0`.
- y_q is never updated from a stale select. It always captures the Y computed from the same-cycle X and sel.

## Timing
- Y has zero cycles of latency (purely combinational).
- y_q and out_valid have one cycle of latency: a value sampled at edge n is visible after edge n.
- Reset values: `y_q = 0` and `out_valid = 0`. These apply immediately when rst is asserted, independent of clk.
- Reset has no effect on Y.
- Reset mid-stream: a capture pending at the edge coincident with rst assertion is dropped. The first capture after release occurs on the first rising edge with `rst=0` and `in_valid=1`.
- Back-to-back `in_valid` produces one result per cycle. There is no backpressure and no stall input.

## Structure
- The shared package `mux_pkg` holds the select constants `SEL_L0..SEL_L3` (2'd0..2'd3) and the default lane width `MUX_W_DEFAULT = 1`.
- One sub-module, `mux_4to1_core`. It is the purely combinational `W`-parameterised lane selector with ports X, sel, Y.
- The top level `mux_4to1` instantiates the core and adds the `y_q`/`out_valid` register stage.

## Test plan
- Exhaustive combinational sweep: drive `{X,sel} = i` for i = 0..63 with W=1, holding each value for 10 ns. Require `Y == X[sel]` every step. Examples:
  - i=0x17 (X=4'b0101, sel=3) → Y=0.
  - i=0x16 (X=4'b0101, sel=2) → Y=1.
  - i=0x3C (X=4'b1111, sel=0) → Y=1.
- One-hot walk: X=4'b0001, 4'b0010, 4'b0100, 4'b1000, each crossed with sel=0..3. Require Y=1 only when sel equals the set-bit index, and 0 otherwise.
- Registered capture: X=4'b1000, sel=3, in_valid=1 for one cycle. Require y_q=1 and out_valid=1 after that edge. On the next edge, with in_valid=0, require out_valid=0 and y_q still 1.
- Async reset: with y_q=1, assert rst mid-cycle. Require y_q=0 and out_valid=0 before the next clk edge, while Y still tracks X/sel.
- Width parameter W=8: X={8'hDD,8'hCC,8'hBB,8'hAA}, sel=2 → Y=8'hCC. Streaming sel=0,1,2,3 with in_valid=1 yields y_q = AA, BB, CC, DD on consecutive cycles.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared select encodings and default lane width for the 4:1 mux
package mux_pkg;
  localparam logic [1:0] SEL_L0 = 2'd0;
  localparam logic [1:0] SEL_L1 = 2'd1;
  localparam logic [1:0] SEL_L2 = 2'd2;
  localparam logic [1:0] SEL_L3 = 2'd3;
  localparam int MUX_W_DEFAULT = 1;
endpackage

// File: rtl/mux_4to1_core.sv
// mux_4to1_core: purely combinational W-bit lane selector, Y = lane sel of X
module mux_4to1_core
  import mux_pkg::*;
#(
  parameter int W = MUX_W_DEFAULT
) (
  input  logic [4*W-1:0] X,
  input  logic [1:0]     sel,
  output logic [W-1:0]   Y
);
  always_comb
    Y = (sel == SEL_L0) ? X[0*W +: W] :
        (sel == SEL_L1) ? X[1*W +: W] :
        (sel == SEL_L2) ? X[2*W +: W] :
                          X[3*W +: W];
endmodule

// File: rtl/mux_4to1.sv
// mux_4to1: 4:1 lane mux with combinational Y and a valid-qualified registered copy
module mux_4to1
  import mux_pkg::*;
#(
  parameter int W = MUX_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [4*W-1:0] X,
  input  logic [1:0]     sel,
  input  logic           in_valid,
  output logic [W-1:0]   Y,
  output logic [W-1:0]   y_q,
  output logic           out_valid
);
  logic [W-1:0] w_y;
  logic [W-1:0] r_y_q;
  logic         r_out_valid;
  mux_4to1_core #(.W(W)) u_core (
    .X   (X),
    .sel (sel),
    .Y   (w_y)
  );
  // capture the same-cycle select result; hold data when not valid
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_y_q       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) r_y_q <= w_y;
    end
  assign Y         = w_y;
  assign y_q       = r_y_q;
  assign out_valid = r_out_valid;
endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1: directed checks of W=1 and W=8 muxes against a shift-and-mask model
module tb_mux_4to1;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] x1;
  logic [1:0] s1;
  logic       iv1;
  logic       y1, yq1, ov1;
  logic [31:0] x8;
  logic [1:0]  s8;
  logic        iv8;
  logic [7:0]  y8, yq8;
  logic        ov8;
  int checks = 0;
  int errors = 0;
  logic       m_q1 = 1'b0, m_v1 = 1'b0;
  logic [7:0] m_q8 = 8'h00;
  logic       m_v8 = 1'b0;

  mux_4to1 #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .X(x1), .sel(s1), .in_valid(iv1),
    .Y(y1), .y_q(yq1), .out_valid(ov1)
  );
  mux_4to1 #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .X(x8), .sel(s8), .in_valid(iv8),
    .Y(y8), .y_q(yq8), .out_valid(ov8)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lane(input logic [31:0] x, input logic [1:0] s, input int w);
    return (x >> (int'(s) * w)) & ((32'd1 << w) - 32'd1);
  endfunction

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endtask

  // reference register stage
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_q1 = 1'b0; m_v1 = 1'b0; m_q8 = 8'h00; m_v8 = 1'b0;
    end else begin
      m_v1 = iv1;
      if (iv1) m_q1 = lane({28'd0, x1}, s1, 1) != 0;
      m_v8 = iv8;
      if (iv8) m_q8 = 8'(lane(x8, s8, 8));
    end

  always @(negedge clk) begin
    check("y_w1", {31'd0, y1}, lane({28'd0, x1}, s1, 1));
    check("yq_w1", {31'd0, yq1}, {31'd0, m_q1});
    check("ov_w1", {31'd0, ov1}, {31'd0, m_v1});
    check("y_w8", {24'd0, y8}, lane(x8, s8, 8));
    check("yq_w8", {24'd0, yq8}, {24'd0, m_q8});
    check("ov_w8", {31'd0, ov8}, {31'd0, m_v8});
  end

  initial begin
    logic [7:0] exp8 [4];
    exp8 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    rst = 1'b1; x1 = '0; s1 = '0; iv1 = 1'b0; x8 = '0; s8 = '0; iv8 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("reset_yq", {31'd0, yq1}, 32'd0);
    check("reset_ov", {31'd0, ov1}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #2 {x1, s1} = 6'(i);
      #1;
      if (i == 'h17) check("sweep_17", {31'd0, y1}, 32'd0);
      if (i == 'h16) check("sweep_16", {31'd0, y1}, 32'd1);
      if (i == 'h3C) check("sweep_3c", {31'd0, y1}, 32'd1);
    end
    for (int b = 0; b < 4; b++)
      for (int s = 0; s < 4; s++) begin
        x1 = 4'(1 << b); s1 = 2'(s);
        #1 check("onehot", {31'd0, y1}, (s == b) ? 32'd1 : 32'd0);
      end
    @(posedge clk);
    #2 x1 = 4'b1000; s1 = 2'd3; iv1 = 1'b1;
    @(posedge clk);
    #2 iv1 = 1'b0;
    check("cap_yq", {31'd0, yq1}, 32'd1);
    check("cap_ov", {31'd0, ov1}, 32'd1);
    @(posedge clk);
    #2 check("hold_yq", {31'd0, yq1}, 32'd1);
    check("hold_ov", {31'd0, ov1}, 32'd0);
    rst = 1'b1;
    #1 check("arst_yq", {31'd0, yq1}, 32'd0);
    check("arst_ov", {31'd0, ov1}, 32'd0);
    x1 = 4'b0100; s1 = 2'd2; iv1 = 1'b1;
    #1 check("arst_y", {31'd0, y1}, 32'd1);
    @(posedge clk);
    #2 check("drop_yq", {31'd0, yq1}, 32'd0);
    check("drop_ov", {31'd0, ov1}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #2 iv1 = 1'b0;
    check("post_rst_yq", {31'd0, yq1}, 32'd1);
    check("post_rst_ov", {31'd0, ov1}, 32'd1);
    x8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA}; s8 = 2'd2;
    #1 check("w8_comb", {24'd0, y8}, 32'hCC);
    @(posedge clk);
    #2 s8 = 2'd0; iv8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #2 check("w8_stream", {24'd0, yq8}, {24'd0, exp8[k]});
      check("w8_stream_ov", {31'd0, ov8}, 32'd1);
      if (k < 3) s8 = 2'(k + 1);
      else iv8 = 1'b0;
    end
    repeat (2) @(posedge clk);
    #2 check("w8_hold", {24'd0, yq8}, 32'hDD);
    check("w8_idle_ov", {31'd0, ov8}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
